// File: rtl/dtcm_bank_arbiter_pkg.sv
// Shared constants and types for the DTCM bank arbiter.
//   DTCM_DW / DTCM_SW : bank data width and byte-strobe width
//   BANK_SEL_BIT      : byte-address bit that selects bank A (0) or B (1)
//   REQ_LSU / REQ_DBG : requester indices on the arbiter ports
package dtcm_bank_arbiter_pkg;

    localparam int DTCM_DW      = 64;
    localparam int DTCM_SW      = 8;
    localparam int BANK_SEL_BIT = 3;
    localparam int NUM_REQ      = 2;
    localparam int NUM_BANKS    = 2;
    localparam int REQ_LSU      = 0;
    localparam int REQ_DBG      = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dtcm_bank_arbiter_if.sv
// Requester and SRAM-side signal bundle of the DTCM bank arbiter.
//   master : requester side (drives req_*, sees req_ready and rsp_*)
//   slave  : arbiter side
//   mem    : SRAM side (sees bank_*, drives bank_rdata)
// Packed [1:0] dimension is the requester index (bit0 = LSU) on req_/rsp_
// signals and the bank index (bit0 = bank A) on bank_ signals.
interface dtcm_bank_arbiter_if #(
    parameter int AW = 16
);
    import dtcm_bank_arbiter_pkg::*;

    localparam int RW = AW - 4;

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0][AW-1:0]          req_addr;
    logic [NUM_REQ-1:0]                  req_wen;
    logic [NUM_REQ-1:0][DTCM_DW-1:0]     req_wdata;
    logic [NUM_REQ-1:0][DTCM_SW-1:0]     req_wstrb;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic [NUM_REQ-1:0][DTCM_DW-1:0]     rsp_rdata;

    logic [NUM_BANKS-1:0]                bank_en;
    logic [NUM_BANKS-1:0]                bank_wen;
    logic [NUM_BANKS-1:0][RW-1:0]        bank_addr;
    logic [NUM_BANKS-1:0][DTCM_DW-1:0]   bank_wdata;
    logic [NUM_BANKS-1:0][DTCM_SW-1:0]   bank_wstrb;
    logic [NUM_BANKS-1:0][DTCM_DW-1:0]   bank_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata,
        output bank_en, bank_wen, bank_addr, bank_wdata, bank_wstrb,
        input  bank_rdata
    );

    modport mem (
        input  bank_en, bank_wen, bank_addr, bank_wdata, bank_wstrb,
        output bank_rdata
    );

endinterface

// File: rtl/dtcm_rr_pick.sv
// Two-way round-robin picker for one DTCM bank.
//   clk, rst_n : clock, async active-low reset
//   en         : arbitration enabled (low during zero-fill -> no grants)
//   req[1:0]   : requesters targeting this bank
//   gnt[1:0]   : one-hot grant (or zero)
// The pointer names the requester that wins the next tie. It only moves on a
// contended grant, and then to the loser, so a lone requester never steals
// the other's turn.
module dtcm_rr_pick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) gnt = ptr ? 2'b10 : 2'b01;
            else      gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ptr <= 1'b0;
        else if (en && &req)  ptr <= ~ptr;
    end

endmodule

// File: rtl/dtcm_bank_arbiter.sv
// Shares DTCM banks A (addr[3]=0) and B (addr[3]=1) between the LSU (port 0)
// and the debug/loader port (port 1), and zero-fills both banks after reset.
//   CLK, RSTn  : clock, async active-low reset
//   init_done  : high once zero-fill has finished
//   bus        : requester handshake, responses and SRAM bank signals
// Grants are combinational and drive the SRAM in the same cycle; the response
// (read data or write ack) follows one cycle later with no backpressure.
module dtcm_bank_arbiter
    import dtcm_bank_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int INIT_CLEAR = 1,
    parameter int INIT_DEPTH = 1000
) (
    input  logic                CLK,
    input  logic                RSTn,
    output logic                init_done,
    dtcm_bank_arbiter_if.slave  bus
);

    localparam int RW = AW - 4;

    arb_state_e                          state;
    logic [RW-1:0]                       init_cnt;
    logic                                run;

    logic [NUM_REQ-1:0]                  req_bank;
    logic [NUM_BANKS-1:0][NUM_REQ-1:0]   bank_req;
    logic [NUM_BANKS-1:0][NUM_REQ-1:0]   bank_gnt;
    logic [NUM_BANKS-1:0]                bank_win;

    logic [NUM_REQ-1:0]                  rsp_vld_q;
    logic [NUM_REQ-1:0]                  rsp_rd_q;
    logic [NUM_REQ-1:0]                  rsp_bank_q;

    // Byte lanes below the 64-bit word are meaningless to the banks.
    logic unused_lsb;
    assign unused_lsb = ^{bus.req_addr[0][2:0], bus.req_addr[1][2:0]};

    assign run = (state == ST_RUN);

    // Route each request to the bank its address selects.
    always_comb begin
        bank_req = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_bank[r] = bus.req_addr[r][BANK_SEL_BIT];
            for (int b = 0; b < NUM_BANKS; b++)
                bank_req[b][r] = bus.req_valid[r] && (req_bank[r] == 1'(b));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dtcm_rr_pick u_pick (
            .clk   (CLK),
            .rst_n (RSTn),
            .en    (run),
            .req   (bank_req[b]),
            .gnt   (bank_gnt[b])
        );
        assign bank_win[b] = bank_gnt[b][REQ_DBG];
    end

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++)
            bus.req_ready[r] = bank_gnt[req_bank[r]][r];
    end

    // SRAM drive: zero-fill both banks while in INIT, else the bank winner.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!run) begin
                bus.bank_en[b]    = 1'b1;
                bus.bank_wen[b]   = 1'b1;
                bus.bank_addr[b]  = init_cnt;
                bus.bank_wdata[b] = '0;
                bus.bank_wstrb[b] = '1;
            end else begin
                bus.bank_en[b]    = |bank_gnt[b];
                bus.bank_wen[b]   = (|bank_gnt[b]) && bus.req_wen[bank_win[b]];
                bus.bank_addr[b]  = bus.req_addr[bank_win[b]][AW-1:4];
                bus.bank_wdata[b] = bus.req_wdata[bank_win[b]];
                bus.bank_wstrb[b] = bus.req_wstrb[bank_win[b]];
            end
        end
    end

    // Remember per requester whether it was granted, whether it was a read,
    // and which bank it hit; the SRAM returns data one cycle after enable.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rsp_vld_q  <= '0;
            rsp_rd_q   <= '0;
            rsp_bank_q <= '0;
        end else begin
            rsp_vld_q  <= bus.req_ready;
            rsp_rd_q   <= ~bus.req_wen;
            rsp_bank_q <= req_bank;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.rsp_valid[r] = rsp_vld_q[r];
            bus.rsp_rdata[r] = (rsp_vld_q[r] && rsp_rd_q[r]) ?
                               bus.bank_rdata[rsp_bank_q[r]] : '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            init_cnt  <= '0;
            init_done <= (INIT_CLEAR == 0);
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == RW'(INIT_DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dtcm_bank_arbiter.sv
module tb_dtcm_bank_arbiter;
    import dtcm_bank_arbiter_pkg::*;

    localparam int AW    = 16;
    localparam int RW    = AW - 4;
    localparam int DEPTH = 1000;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic init_done;

    always #5 CLK = ~CLK;

    dtcm_bank_arbiter_if #(.AW(AW)) bus ();

    dtcm_bank_arbiter #(.AW(AW), .INIT_CLEAR(1), .INIT_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .init_done (init_done),
        .bus       (bus.slave)
    );

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] s);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) res[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        return res;
    endfunction

    // Write-first SRAM pair. Storage is kept inverted so a never-written row
    // reads back as non-zero, which makes the zero-fill observable.
    logic [63:0] sram_n [2][1 << RW];
    always @(posedge CLK) begin
        for (int b = 0; b < 2; b++) begin
            if (bus.bank_en[b]) begin
                if (bus.bank_wen[b]) begin
                    sram_n[b][bus.bank_addr[b]] <= ~merge(~sram_n[b][bus.bank_addr[b]],
                                                          bus.bank_wdata[b], bus.bank_wstrb[b]);
                    bus.bank_rdata[b] <= merge(~sram_n[b][bus.bank_addr[b]],
                                               bus.bank_wdata[b], bus.bank_wstrb[b]);
                end else begin
                    bus.bank_rdata[b] <= ~sram_n[b][bus.bank_addr[b]];
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: flat memory of 64-bit words indexed by byte address >> 3,
    // plus per-bank "who wins the next tie".
    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    logic [63:0] ref_mem [int];
    int          favor [2];
    exp_t        sbq [2][$];
    logic [63:0] last_rdata [2];

    // Monitor: every response must arrive exactly on its due cycle.
    initial begin
        forever begin
            @(negedge CLK);
            for (int r = 0; r < 2; r++) begin
                logic due_now;
                exp_t e;
                due_now = (sbq[r].size() > 0) && (sbq[r][0].due == cyc);
                if (due_now || bus.rsp_valid[r]) begin
                    chk($sformatf("rsp_valid[%0d]", r), 64'(bus.rsp_valid[r]), 64'(due_now));
                    if (due_now) begin
                        e = sbq[r].pop_front();
                        chk($sformatf("rsp_rdata[%0d]", r), bus.rsp_rdata[r], e.data);
                        last_rdata[r] = bus.rsp_rdata[r];
                    end
                end
            end
        end
    end

    // Drive one cycle of requests, check the grants, queue the expected responses.
    task automatic issue(input logic [1:0] v, input logic [1:0][AW-1:0] a,
                         input logic [1:0] w, input logic [1:0][63:0] d,
                         input logic [1:0][7:0] s, output logic [1:0] rdy);
        logic [1:0]  g;
        logic        cont;
        int          key;
        logic [63:0] old;
        exp_t        e;
        @(negedge CLK);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        #2;
        for (int r = 0; r < 2; r++) begin
            cont = v[0] && v[1] && (a[0][3] == a[1][3]);
            g[r] = v[r] && (!cont || favor[int'(a[r][3])] == r);
        end
        chk("req_ready", 64'(bus.req_ready), 64'(g));
        rdy = bus.req_ready;
        for (int r = 0; r < 2; r++) begin
            if (g[r]) begin
                key = int'(a[r] >> 3);
                old = ref_mem.exists(key) ? ref_mem[key] : 64'h0;
                e.due = cyc + 1;
                if (w[r]) begin
                    ref_mem[key] = merge(old, d[r], s[r]);
                    e.data = 64'h0;
                end else begin
                    e.data = old;
                end
                sbq[r].push_back(e);
            end
        end
        if (v == 2'b11 && a[0][3] == a[1][3])
            favor[int'(a[0][3])] = g[0] ? 1 : 0;
    endtask

    task automatic idle(input int n);
        logic [1:0] rdy;
        for (int i = 0; i < n; i++) issue(2'b00, '0, 2'b00, '0, '0, rdy);
    endtask

    // Expects RSTn low on entry; releases it and checks the whole zero-fill.
    task automatic run_init();
        logic [47:0] exp_v;
        bus.req_valid = 2'b11;
        bus.req_addr  = {16'h0018, 16'h0000};
        bus.req_wen   = 2'b00;
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_v = {1'b0, 2'b00, 2'b11, 2'b11, 8'hFF, 8'hFF, RW'(i), RW'(i), 1'b1};
            chk("init_row", 64'({init_done, bus.req_ready, bus.bank_en, bus.bank_wen,
                                 bus.bank_wstrb[0], bus.bank_wstrb[1],
                                 bus.bank_addr[0], bus.bank_addr[1],
                                 (bus.bank_wdata == '0)}), 64'(exp_v));
            @(negedge CLK);
        end
        bus.req_valid = 2'b00;
        #1;
        chk("init_done", 64'({init_done, bus.bank_en}), 64'({1'b1, 2'b00}));
    endtask

    initial begin
        logic [1:0]        rdy;
        logic [1:0]        hv, hw, g;
        logic [1:0][AW-1:0] ha;
        logic [1:0][63:0]  hd;
        logic [1:0][7:0]   hs;
        int                n0, n1;

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_wen   = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        favor[0] = 0;
        favor[1] = 0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;

        repeat (3) @(negedge CLK);
        chk("reset_state", 64'({init_done, bus.rsp_valid, bus.req_ready}), 64'h0);
        run_init();

        // Single write to bank B row 0, then read it back.
        issue(2'b01, {16'h0, 16'h0008}, 2'b01, {64'h0, 64'h1122334455667788},
              {8'h0, 8'hFF}, rdy);
        idle(1);
        issue(2'b01, {16'h0, 16'h0008}, 2'b00, '0, '0, rdy);
        idle(1);
        chk("t2_readback", last_rdata[0], 64'h1122334455667788);

        // Parallel writes then parallel reads on different banks.
        issue(2'b11, {16'h0018, 16'h0000}, 2'b11,
              {64'hA5A5_5A5A_0F0F_F0F0, 64'h0123_4567_89AB_CDEF}, {8'hFF, 8'hFF}, rdy);
        issue(2'b11, {16'h0018, 16'h0000}, 2'b00, '0, '0, rdy);
        chk("t3_both_ready", 64'(rdy), 64'(2'b11));
        idle(1);
        chk("t3_lsu_data", last_rdata[0], 64'h0123_4567_89AB_CDEF);
        chk("t3_dbg_data", last_rdata[1], 64'hA5A5_5A5A_0F0F_F0F0);

        // Continuous contention on bank A.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            issue(2'b11, {16'h0010, 16'h0000}, 2'b00, '0, '0, rdy);
            n0 += int'(rdy[0]);
            n1 += int'(rdy[1]);
        end
        idle(1);
        chk("t4_lsu_grants", 64'(n0), 64'd3);
        chk("t4_dbg_grants", 64'(n1), 64'd3);

        // Partial-strobe write to a cleared row, read back the very next cycle.
        issue(2'b01, {16'h0, 16'h0100}, 2'b01, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF},
              {8'h0, 8'h0F}, rdy);
        issue(2'b01, {16'h0, 16'h0100}, 2'b00, '0, '0, rdy);
        idle(1);
        chk("t5_strobe", last_rdata[0], 64'h0000_0000_FFFF_FFFF);

        // Random traffic on a few rows of both banks; stalled requests are held.
        hv = '0; hw = '0; ha = '0; hd = '0; hs = '0; g = '0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!(hv[r] && !g[r])) begin
                    hv[r] = ($urandom % 4) != 0;
                    ha[r] = AW'((($urandom % 8) << 4) | (($urandom % 2) << 3) | ($urandom % 8));
                    hw[r] = $urandom % 2;
                    hd[r] = {$urandom, $urandom};
                    hs[r] = 8'($urandom);
                end
            end
            issue(hv, ha, hw, hd, hs, g);
        end
        idle(3);

        // Reset during a read grant: the response must be dropped.
        @(negedge CLK);
        bus.req_valid = 2'b01;
        bus.req_addr  = {16'h0, 16'h0000};
        bus.req_wen   = 2'b00;
        #2;
        RSTn = 1'b0;
        bus.req_valid = 2'b00;
        repeat (3) @(negedge CLK);
        chk("t6_no_rsp", 64'(bus.rsp_valid), 64'h0);
        ref_mem.delete();
        favor[0] = 0;
        favor[1] = 0;
        run_init();
        issue(2'b11, {16'h0008, 16'h0000}, 2'b00, '0, '0, rdy);
        idle(3);
        chk("sb_empty", 64'(sbq[0].size() + sbq[1].size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
